// File: rtl/uart_sys_ctrl_pkg.sv
// Shared constants and state encoding for the UART command-frame controllers.
package uart_sys_ctrl_pkg;

  // Command bytes that open a frame
  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  // Register-file slots that hold the ALU operands
  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  // Receive-side frame parser states
  typedef enum logic [2:0] {
    StIdle,
    StWrAddr,
    StWrData,
    StRdAddr,
    StOpA,
    StOpB,
    StFunc,
    StExec
  } rx_state_e;

  // True while an ALU frame (CC or DD) is in flight
  function automatic logic is_alu_state(input rx_state_e s);
    return (s == StOpA) || (s == StOpB) || (s == StFunc) || (s == StExec);
  endfunction

endpackage

// File: rtl/frame_timeout_counter.sv
// Inter-byte timeout counter: counts enabled cycles since the last clear and
// pulses expired on the cycle the count would reach TIMEOUT_CYCLES.
module frame_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] count_q, count_d;

  // Clear wins over counting; the count holds while enable is low
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = (count_q == LastCnt) ? '0 : count_q + CntW'(1);
    end
  end

  // A clear in the expiring cycle (an accepted byte) suppresses the pulse
  assign expired = enable & ~clear & (count_q == LastCnt);

  // Count register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_receiver_controller.sv
// Command-frame parser: turns received UART bytes into register-file and ALU
// strobes. All outputs are registered and pulse one cycle after acceptance.
module uart_receiver_controller
  import uart_sys_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned FUNC_WIDTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  receiver_parallel_data_valid,
  input  logic [DATA_WIDTH-1:0] receiver_parallel_data,
  input  logic                  uart_receiver_controller_en,
  output logic                  rf_write_en,
  output logic                  rf_read_en,
  output logic [ADDR_WIDTH-1:0] rf_address,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic                  alu_en,
  output logic [FUNC_WIDTH-1:0] alu_function,
  output logic                  alu_clock_gate_en,
  output logic                  frame_error
);

  rx_state_e             state_q, state_d;
  logic                  rf_write_en_q, rf_write_en_d;
  logic                  rf_read_en_q, rf_read_en_d;
  logic [ADDR_WIDTH-1:0] rf_address_q, rf_address_d;
  logic [DATA_WIDTH-1:0] rf_write_data_q, rf_write_data_d;
  logic                  alu_en_q, alu_en_d;
  logic [FUNC_WIDTH-1:0] alu_function_q, alu_function_d;
  logic                  gate_q, gate_d;
  logic                  frame_error_q, frame_error_d;
  logic                  exec_done_q;

  logic accept;
  logic tmo_clear, tmo_expired, tmo_abort;

  assign accept    = receiver_parallel_data_valid & uart_receiver_controller_en;
  assign tmo_clear = accept | (state_q == StIdle);
  // EXEC always leaves on its own, so only byte-waiting states can time out
  assign tmo_abort = tmo_expired & (state_q != StIdle) & (state_q != StExec);

  frame_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (tmo_clear),
    .enable (uart_receiver_controller_en),
    .expired(tmo_expired)
  );

  // Next-state and next-output decode for the frame parser
  always_comb begin
    state_d         = state_q;
    rf_write_en_d   = 1'b0;
    rf_read_en_d    = 1'b0;
    alu_en_d        = 1'b0;
    frame_error_d   = 1'b0;
    rf_address_d    = rf_address_q;
    rf_write_data_d = rf_write_data_q;
    alu_function_d  = alu_function_q;
    gate_d          = gate_q;

    // Gate falls one cycle after alu_en unless a new ALU frame already started
    if (exec_done_q && !is_alu_state(state_q)) begin
      gate_d = 1'b0;
    end

    case (state_q)
      StIdle, StExec: begin
        state_d = StIdle;
        if (accept) begin
          if (receiver_parallel_data == DATA_WIDTH'(CMD_RF_WR)) begin
            state_d = StWrAddr;
          end else if (receiver_parallel_data == DATA_WIDTH'(CMD_RF_RD)) begin
            state_d = StRdAddr;
          end else if (receiver_parallel_data == DATA_WIDTH'(CMD_ALU_OP)) begin
            state_d = StOpA;
            gate_d  = 1'b1;
          end else if (receiver_parallel_data == DATA_WIDTH'(CMD_ALU_NOP)) begin
            state_d = StFunc;
            gate_d  = 1'b1;
          end else begin
            frame_error_d = 1'b1;
          end
        end
      end
      StWrAddr: begin
        if (accept) begin
          rf_address_d = receiver_parallel_data[ADDR_WIDTH-1:0];
          state_d      = StWrData;
        end
      end
      StWrData: begin
        if (accept) begin
          rf_write_data_d = receiver_parallel_data;
          rf_write_en_d   = 1'b1;
          state_d         = StIdle;
        end
      end
      StRdAddr: begin
        if (accept) begin
          rf_address_d = receiver_parallel_data[ADDR_WIDTH-1:0];
          rf_read_en_d = 1'b1;
          state_d      = StIdle;
        end
      end
      StOpA: begin
        if (accept) begin
          rf_address_d    = ADDR_WIDTH'(OPA_ADDR);
          rf_write_data_d = receiver_parallel_data;
          rf_write_en_d   = 1'b1;
          state_d         = StOpB;
        end
      end
      StOpB: begin
        if (accept) begin
          rf_address_d    = ADDR_WIDTH'(OPB_ADDR);
          rf_write_data_d = receiver_parallel_data;
          rf_write_en_d   = 1'b1;
          state_d         = StFunc;
        end
      end
      StFunc: begin
        if (accept) begin
          alu_function_d = receiver_parallel_data[FUNC_WIDTH-1:0];
          alu_en_d       = 1'b1;
          state_d        = StExec;
        end
      end
      default: state_d = StIdle;
    endcase

    if (tmo_abort) begin
      state_d       = StIdle;
      frame_error_d = 1'b1;
      gate_d        = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      rf_write_en_q   <= 1'b0;
      rf_read_en_q    <= 1'b0;
      rf_address_q    <= '0;
      rf_write_data_q <= '0;
      alu_en_q        <= 1'b0;
      alu_function_q  <= '0;
      gate_q          <= 1'b0;
      frame_error_q   <= 1'b0;
      exec_done_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      rf_write_en_q   <= rf_write_en_d;
      rf_read_en_q    <= rf_read_en_d;
      rf_address_q    <= rf_address_d;
      rf_write_data_q <= rf_write_data_d;
      alu_en_q        <= alu_en_d;
      alu_function_q  <= alu_function_d;
      gate_q          <= gate_d;
      frame_error_q   <= frame_error_d;
      exec_done_q     <= (state_q == StExec);
    end
  end

  assign rf_write_en       = rf_write_en_q;
  assign rf_read_en        = rf_read_en_q;
  assign rf_address        = rf_address_q;
  assign rf_write_data     = rf_write_data_q;
  assign alu_en            = alu_en_q;
  assign alu_function      = alu_function_q;
  assign alu_clock_gate_en = gate_q;
  assign frame_error       = frame_error_q;

endmodule

// File: tb/tb_uart_receiver_controller.sv
// Self-checking bench: directed vector table, hand-written timeout/reset
// sequences, then random traffic against a frame-level reference model.
module tb_uart_receiver_controller;

  localparam int unsigned TMO = 64;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       valid = 1'b0;
  logic       en = 1'b0;
  logic [7:0] data = 8'h00;

  logic       rf_write_en, rf_read_en, alu_en, alu_clock_gate_en, frame_error;
  logic [3:0] rf_address, alu_function;
  logic [7:0] rf_write_data;

  always #5 clk = ~clk;

  uart_receiver_controller #(
    .DATA_WIDTH    (8),
    .ADDR_WIDTH    (4),
    .FUNC_WIDTH    (4),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk                         (clk),
    .reset_n                     (reset_n),
    .receiver_parallel_data_valid(valid),
    .receiver_parallel_data      (data),
    .uart_receiver_controller_en (en),
    .rf_write_en                 (rf_write_en),
    .rf_read_en                  (rf_read_en),
    .rf_address                  (rf_address),
    .rf_write_data               (rf_write_data),
    .alu_en                      (alu_en),
    .alu_function                (alu_function),
    .alu_clock_gate_en           (alu_clock_gate_en),
    .frame_error                 (frame_error)
  );

  typedef struct packed {
    logic       we;
    logic       re;
    logic [3:0] addr;
    logic [7:0] wd;
    logic       alu;
    logic [3:0] fn;
    logic       gate;
    logic       ferr;
  } out_t;

  typedef struct {
    logic       v;
    logic       en;
    logic [7:0] d;
    out_t       exp;
  } vec_t;

  int   n_checks = 0;
  int   n_fail = 0;
  vec_t vecs[$];

  function automatic out_t o(input logic we, input logic re, input logic [3:0] addr,
                             input logic [7:0] wd, input logic alu, input logic [3:0] fn,
                             input logic gate, input logic ferr);
    out_t r;
    r.we = we; r.re = re; r.addr = addr; r.wd = wd;
    r.alu = alu; r.fn = fn; r.gate = gate; r.ferr = ferr;
    return r;
  endfunction

  task automatic check_out(input string name, input out_t exp);
    out_t act;
    act = o(rf_write_en, rf_read_en, rf_address, rf_write_data, alu_en, alu_function,
            alu_clock_gate_en, frame_error);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got we=%b re=%b addr=%h wd=%h alu_en=%b fn=%h gate=%b ferr=%b, want we=%b re=%b addr=%h wd=%h alu_en=%b fn=%h gate=%b ferr=%b",
               name, act.we, act.re, act.addr, act.wd, act.alu, act.fn, act.gate, act.ferr,
               exp.we, exp.re, exp.addr, exp.wd, exp.alu, exp.fn, exp.gate, exp.ferr);
    end
  endtask

  task automatic drive(input logic v, input logic e, input logic [7:0] d);
    valid = v;
    en    = e;
    data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic v, input logic e, input logic [7:0] d, input out_t exp);
    vec_t t;
    t.v = v; t.en = e; t.d = d; t.exp = exp;
    vecs.push_back(t);
  endtask

  // Reference model: tracks the bytes of the current frame and expected outputs
  out_t       m_exp;
  logic [7:0] frm[$];
  int         m_idle;
  bit         m_post_exec;

  function automatic void model_reset();
    m_exp = '0;
    frm.delete();
    m_idle = 0;
    m_post_exec = 1'b0;
  endfunction

  function automatic void model_step(input logic v, input logic e, input logic [7:0] d);
    bit post;
    post = m_post_exec;
    m_post_exec = m_exp.alu;
    m_exp.we = 1'b0; m_exp.re = 1'b0; m_exp.alu = 1'b0; m_exp.ferr = 1'b0;
    if (post && !(frm.size() > 0 && (frm[0] == 8'hCC || frm[0] == 8'hDD)))
      m_exp.gate = 1'b0;
    if (v && e) begin
      m_idle = 0;
      if (frm.size() == 0) begin
        if (d == 8'hAA || d == 8'hBB || d == 8'hCC || d == 8'hDD) begin
          frm.push_back(d);
          if (d == 8'hCC || d == 8'hDD) m_exp.gate = 1'b1;
        end else begin
          m_exp.ferr = 1'b1;
        end
      end else begin
        int pos;
        logic [7:0] cmd;
        pos = frm.size();
        cmd = frm[0];
        frm.push_back(d);
        if (cmd == 8'hAA) begin
          if (pos == 1) m_exp.addr = d[3:0];
          else begin m_exp.wd = d; m_exp.we = 1'b1; frm.delete(); end
        end else if (cmd == 8'hBB) begin
          m_exp.addr = d[3:0]; m_exp.re = 1'b1; frm.delete();
        end else if (cmd == 8'hCC && pos < 3) begin
          m_exp.addr = 4'(pos - 1); m_exp.wd = d; m_exp.we = 1'b1;
        end else begin
          m_exp.fn = d[3:0]; m_exp.alu = 1'b1; frm.delete();
        end
      end
    end else if (e && frm.size() > 0) begin
      m_idle++;
      if (m_idle == TMO) begin
        m_exp.ferr = 1'b1; m_exp.gate = 1'b0; frm.delete(); m_idle = 0;
      end
    end
  endfunction

  logic [7:0] cmds[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

  initial begin
    // Directed table: {valid, en, byte} -> outputs after the next edge
    add(1, 1, 8'hAA, o(0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 0));
    add(1, 1, 8'h05, o(0, 0, 4'h5, 8'h00, 0, 4'h0, 0, 0));
    add(1, 1, 8'h3C, o(1, 0, 4'h5, 8'h3C, 0, 4'h0, 0, 0));
    add(0, 1, 8'h00, o(0, 0, 4'h5, 8'h3C, 0, 4'h0, 0, 0));
    add(1, 1, 8'hBB, o(0, 0, 4'h5, 8'h3C, 0, 4'h0, 0, 0));
    add(1, 1, 8'h0A, o(0, 1, 4'hA, 8'h3C, 0, 4'h0, 0, 0));
    add(0, 1, 8'h00, o(0, 0, 4'hA, 8'h3C, 0, 4'h0, 0, 0));
    add(1, 1, 8'hCC, o(0, 0, 4'hA, 8'h3C, 0, 4'h0, 1, 0));
    add(1, 1, 8'h12, o(1, 0, 4'h0, 8'h12, 0, 4'h0, 1, 0));
    add(1, 1, 8'h34, o(1, 0, 4'h1, 8'h34, 0, 4'h0, 1, 0));
    add(1, 1, 8'h02, o(0, 0, 4'h1, 8'h34, 1, 4'h2, 1, 0));
    add(0, 1, 8'h00, o(0, 0, 4'h1, 8'h34, 0, 4'h2, 1, 0));
    add(0, 1, 8'h00, o(0, 0, 4'h1, 8'h34, 0, 4'h2, 0, 0));
    add(1, 1, 8'h55, o(0, 0, 4'h1, 8'h34, 0, 4'h2, 0, 1));
    add(1, 1, 8'hDD, o(0, 0, 4'h1, 8'h34, 0, 4'h2, 1, 0));
    add(1, 1, 8'h01, o(0, 0, 4'h1, 8'h34, 1, 4'h1, 1, 0));
    add(0, 1, 8'h00, o(0, 0, 4'h1, 8'h34, 0, 4'h1, 1, 0));
    add(0, 1, 8'h00, o(0, 0, 4'h1, 8'h34, 0, 4'h1, 0, 0));
    add(1, 0, 8'hAA, o(0, 0, 4'h1, 8'h34, 0, 4'h1, 0, 0));
    add(1, 1, 8'h0B, o(0, 0, 4'h1, 8'h34, 0, 4'h1, 0, 1));
    add(0, 1, 8'h00, o(0, 0, 4'h1, 8'h34, 0, 4'h1, 0, 0));
    add(1, 1, 8'hDD, o(0, 0, 4'h1, 8'h34, 0, 4'h1, 1, 0));
    add(1, 1, 8'h03, o(0, 0, 4'h1, 8'h34, 1, 4'h3, 1, 0));
    add(1, 1, 8'hAA, o(0, 0, 4'h1, 8'h34, 0, 4'h3, 1, 0));
    add(1, 1, 8'h07, o(0, 0, 4'h7, 8'h34, 0, 4'h3, 0, 0));
    add(1, 1, 8'h99, o(1, 0, 4'h7, 8'h99, 0, 4'h3, 0, 0));
    add(0, 1, 8'h00, o(0, 0, 4'h7, 8'h99, 0, 4'h3, 0, 0));

    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_state", o(0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 0));
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].en, vecs[i].d);
      check_out($sformatf("vec%0d", i), vecs[i].exp);
    end

    // A byte landing on the would-be expiry cycle wins; en=0 cycles do not count
    drive(1, 1, 8'hAA);
    check_out("tmo_a_cmd", o(0, 0, 4'h7, 8'h99, 0, 4'h3, 0, 0));
    drive(1, 1, 8'h03);
    check_out("tmo_a_addr", o(0, 0, 4'h3, 8'h99, 0, 4'h3, 0, 0));
    for (int i = 1; i <= int'(TMO) - 1 + 5; i++) begin
      drive(0, !(i >= 10 && i < 15), 8'h00);
      check_out($sformatf("tmo_a_wait%0d", i), o(0, 0, 4'h3, 8'h99, 0, 4'h3, 0, 0));
    end
    drive(1, 1, 8'h5A);
    check_out("tmo_a_byte_wins", o(1, 0, 4'h3, 8'h5A, 0, 4'h3, 0, 0));

    // Full timeout: abort with frame_error and no write strobe
    drive(1, 1, 8'hAA);
    check_out("tmo_b_cmd", o(0, 0, 4'h3, 8'h5A, 0, 4'h3, 0, 0));
    drive(1, 1, 8'h04);
    check_out("tmo_b_addr", o(0, 0, 4'h4, 8'h5A, 0, 4'h3, 0, 0));
    for (int i = 1; i <= int'(TMO); i++) begin
      drive(0, 1, 8'h00);
      check_out($sformatf("tmo_b_wait%0d", i),
                o(0, 0, 4'h4, 8'h5A, 0, 4'h3, 0, logic'(i == int'(TMO))));
    end
    drive(0, 1, 8'h00);
    check_out("tmo_b_after", o(0, 0, 4'h4, 8'h5A, 0, 4'h3, 0, 0));
    drive(1, 1, 8'hBB);
    check_out("tmo_b_rd_cmd", o(0, 0, 4'h4, 8'h5A, 0, 4'h3, 0, 0));
    drive(1, 1, 8'h03);
    check_out("tmo_b_rd", o(0, 1, 4'h3, 8'h5A, 0, 4'h3, 0, 0));

    // Asynchronous reset in the middle of an ALU frame
    drive(1, 1, 8'hCC);
    check_out("rst_cmd", o(0, 0, 4'h3, 8'h5A, 0, 4'h3, 1, 0));
    drive(1, 1, 8'h11);
    check_out("rst_opa", o(1, 0, 4'h0, 8'h11, 0, 4'h3, 1, 0));
    valid = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    check_out("rst_async", o(0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1, 1, 8'hAA);
    check_out("rst_wr_cmd", o(0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 0));
    drive(1, 1, 8'h01);
    check_out("rst_wr_addr", o(0, 0, 4'h1, 8'h00, 0, 4'h0, 0, 0));
    drive(1, 1, 8'hFF);
    check_out("rst_wr_data", o(1, 0, 4'h1, 8'hFF, 0, 4'h0, 0, 0));
    drive(0, 1, 8'h00);
    check_out("rst_wr_done", o(0, 0, 4'h1, 8'hFF, 0, 4'h0, 0, 0));

    // Random traffic against the reference model
    valid = 1'b0;
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    begin
      int gap;
      logic v, e;
      logic [7:0] d;
      gap = 0;
      for (int c = 0; c < 3000; c++) begin
        if (gap > 0) begin
          gap--;
          v = 1'b0;
          e = ($urandom_range(0, 19) != 0);
          d = 8'h00;
        end else begin
          v = ($urandom_range(0, 99) < 45);
          e = ($urandom_range(0, 9) != 0);
          if ($urandom_range(0, 9) < 5) d = cmds[$urandom_range(0, 3)];
          else d = 8'($urandom);
          if ($urandom_range(0, 149) == 0) gap = int'(TMO) - 2 + int'($urandom_range(0, 4));
        end
        // Keep en high through the single EXEC cycle
        if (m_exp.alu) e = 1'b1;
        model_step(v, e, d);
        drive(v, e, d);
        check_out($sformatf("rand%0d", c), m_exp);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
